// File: rtl/reset_sequencer_if.sv
// Reset sequencer request/status bundle: the button and software request
// inputs plus the per-domain resets and diagnostic outputs.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   ext_reset_n;
  logic                   sw_reset_req;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic                   all_released;
  logic [1:0]             reset_cause;
  logic [7:0]             warm_reset_count;

  // Requester side: raises reset requests, observes the resets and diagnostics.
  modport master (
    output ext_reset_n, sw_reset_req,
    input  domain_reset, all_released, reset_cause, warm_reset_count
  );

  // Sequencer side.
  modport slave (
    input  ext_reset_n, sw_reset_req,
    output domain_reset, all_released, reset_cause, warm_reset_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / warm reset sequencer. Holds every domain in reset, then
// releases them one by one in index order. Warm restarts come from a
// debounced active-low button or a one-cycle software request; the cause of
// the last reset and a saturating warm-reset count are kept for diagnostics.
module reset_sequencer #(
  parameter int NUM_DOMAINS     = 3,
  parameter int HOLD_CYCLES     = 15,
  parameter int STAGE_CYCLES    = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input logic              clock,
  input logic              reset,
  reset_sequencer_if.slave bus
);
  localparam int MAX_HS  = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
  localparam int MAX_CYC = (MAX_HS > DEBOUNCE_CYCLES) ? MAX_HS : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] CAUSE_RESET  = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_SW     = 2'd2;
  localparam logic [1:0] CAUSE_BOTH   = 2'd3;

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN, S_BUTTON} state_t;

  // Warm-reset counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_q, btn_d;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic                   btn_raw, btn_diff, btn_toggle, btn_press, btn_rel;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic [NUM_DOMAINS-1:0] dom_shift;
  logic                   all_rel_q;
  logic [1:0]             cause_q;
  logic [7:0]             count_q;

  // Bring the asynchronous button into the clock domain; idle level is high.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ext_reset_n};
  end

  // Debounce: count consecutive disagreeing samples, flip the debounced
  // state on the sample after the count reaches DEBOUNCE_CYCLES.
  always_comb begin
    btn_raw    = ~sync_q[SYNC_STAGES-1];
    btn_diff   = btn_raw ^ btn_q;
    btn_toggle = btn_diff && (dcnt_q == DEB_TARGET);
    btn_press  = btn_toggle && !btn_q;
    btn_rel    = btn_toggle && btn_q;
    btn_d      = btn_q ^ btn_toggle;
    dcnt_d     = '0;
    if (btn_diff && !btn_toggle) dcnt_d = dcnt_q + CNT_ONE;
    // Domains are always released lowest index first, so releasing the next
    // one is a left shift of the still-asserted mask.
    dom_shift  = dom_q << 1;
  end

  // Debounced button state and its stability counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      btn_q  <= btn_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Sequencing FSM with registered domain resets and diagnostics. A button
  // press outranks a software request; a request landing on the press edge
  // only upgrades the cause.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      dom_q     <= '1;
      all_rel_q <= 1'b0;
      cause_q   <= CAUSE_RESET;
      count_q   <= 8'd0;
    end else if (btn_press) begin
      state_q   <= S_BUTTON;
      cnt_q     <= '0;
      dom_q     <= '1;
      all_rel_q <= 1'b0;
      cause_q   <= bus.sw_reset_req ? CAUSE_BOTH : CAUSE_BUTTON;
      count_q   <= sat_inc(count_q);
    end else if (bus.sw_reset_req && (state_q != S_BUTTON)) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      dom_q     <= '1;
      all_rel_q <= 1'b0;
      cause_q   <= CAUSE_SW;
      count_q   <= sat_inc(count_q);
    end else begin
      case (state_q)
        S_HOLD, S_RELEASE: begin
          if (cnt_q == ((state_q == S_HOLD) ? HOLD_LAST : STAGE_LAST)) begin
            cnt_q <= '0;
            dom_q <= dom_shift;
            if (dom_shift == '0) begin
              state_q   <= S_RUN;
              all_rel_q <= 1'b1;
            end else begin
              state_q   <= S_RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_BUTTON: begin
          cnt_q <= '0;
          if (btn_rel) state_q <= S_HOLD;
        end
        default: ;
      endcase
    end
  end

  assign bus.domain_reset     = dom_q;
  assign bus.all_released     = all_rel_q;
  assign bus.reset_cause      = cause_q;
  assign bus.warm_reset_count = count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed stimulus, a timeline-based
// reference model checked every cycle, and a table of hand-computed points.
module tb_reset_sequencer;
  localparam int ND    = 3;
  localparam int HOLD  = 15;
  localparam int STAGE = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   phase = 1;
  int   n_checks = 0;
  int   n_fail   = 0;

  reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS(ND), .HOLD_CYCLES(HOLD), .STAGE_CYCLES(STAGE),
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Edge number since reset release (0 while reset is high).
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         ph;
    int         e;
    logic [2:0] dom;
    logic       ar;
    logic [1:0] cause;
    logic [7:0] cnt;
  } lit_t;

  lit_t lits [31] = '{
    '{1,   0, 3'b111, 1'b0, 2'd0, 8'd0},
    '{1,  14, 3'b111, 1'b0, 2'd0, 8'd0},
    '{1,  15, 3'b110, 1'b0, 2'd0, 8'd0},
    '{1,  19, 3'b100, 1'b0, 2'd0, 8'd0},
    '{1,  22, 3'b100, 1'b0, 2'd0, 8'd0},
    '{1,  23, 3'b000, 1'b1, 2'd0, 8'd0},
    '{1,  40, 3'b111, 1'b0, 2'd2, 8'd1},
    '{1,  54, 3'b111, 1'b0, 2'd2, 8'd1},
    '{1,  55, 3'b110, 1'b0, 2'd2, 8'd1},
    '{1,  63, 3'b000, 1'b1, 2'd2, 8'd1},
    '{1,  90, 3'b000, 1'b1, 2'd2, 8'd1},
    '{1, 109, 3'b000, 1'b1, 2'd2, 8'd1},
    '{1, 110, 3'b111, 1'b0, 2'd1, 8'd2},
    '{1, 144, 3'b111, 1'b0, 2'd1, 8'd2},
    '{1, 145, 3'b110, 1'b0, 2'd1, 8'd2},
    '{1, 153, 3'b000, 1'b1, 2'd1, 8'd2},
    '{1, 160, 3'b111, 1'b0, 2'd2, 8'd3},
    '{1, 176, 3'b110, 1'b0, 2'd2, 8'd3},
    '{1, 177, 3'b111, 1'b0, 2'd2, 8'd4},
    '{1, 192, 3'b110, 1'b0, 2'd2, 8'd4},
    '{1, 200, 3'b000, 1'b1, 2'd2, 8'd4},
    '{1, 220, 3'b111, 1'b0, 2'd3, 8'd5},
    '{1, 255, 3'b110, 1'b0, 2'd3, 8'd5},
    '{1, 263, 3'b000, 1'b1, 2'd3, 8'd5},
    '{1, 766, 3'b111, 1'b0, 2'd2, 8'd254},
    '{1, 768, 3'b111, 1'b0, 2'd2, 8'd255},
    '{1, 788, 3'b111, 1'b0, 2'd2, 8'd255},
    '{1, 811, 3'b000, 1'b1, 2'd2, 8'd255},
    '{2,   0, 3'b111, 1'b0, 2'd0, 8'd0},
    '{2,  15, 3'b110, 1'b0, 2'd0, 8'd0},
    '{2,  23, 3'b000, 1'b1, 2'd0, 8'd0}
  };

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d phase %0d: got %0h, expected %0h", nm, cyc, phase, act, exp);
    end
  endtask

  // Reference model: a sequence starts at some edge S; domain k is low once
  // the edge number reaches S + HOLD + k*STAGE, unless the debounced button
  // is held. The button is seen SYNC edges late and must disagree with its
  // debounced state for DEB+1 consecutive samples to flip it.
  int         m_edge, m_start;
  bit         m_btn, m_deb;
  logic [1:0] m_cause;
  logic [7:0] m_count;
  bit         ext_hist[$];
  bit         raw_win[$];

  always @(posedge clock) begin
    bit         raw, tog, sw;
    logic [2:0] e_dom;
    sw = bus.sw_reset_req;
    if (reset) begin
      m_edge = 0; m_start = 0; m_btn = 0; m_deb = 0;
      m_cause = 2'd0; m_count = 8'd0;
      ext_hist.delete();
      for (int i = 0; i < SYNC; i++) ext_hist.push_back(1'b1);
      raw_win.delete();
    end else begin
      m_edge++;
      raw = !ext_hist.pop_front();
      ext_hist.push_back(bus.ext_reset_n);
      raw_win.push_back(raw);
      if (raw_win.size() > DEB + 1) void'(raw_win.pop_front());
      tog = 0;
      if (raw_win.size() == DEB + 1) begin
        tog = 1;
        foreach (raw_win[i]) if (raw_win[i] == m_deb) tog = 0;
      end
      if (tog) begin
        m_deb = !m_deb;
        raw_win.delete();
      end
      if (tog && m_deb) begin
        m_btn   = 1;
        m_cause = sw ? 2'd3 : 2'd1;
        if (m_count != 8'd255) m_count++;
      end else if (sw && !m_btn) begin
        m_start = m_edge;
        m_cause = 2'd2;
        if (m_count != 8'd255) m_count++;
      end
      if (tog && !m_deb) begin
        m_btn   = 0;
        m_start = m_edge;
      end
    end
    for (int k = 0; k < ND; k++)
      e_dom[k] = m_btn || (m_edge < m_start + HOLD + k * STAGE);
    #1;
    chk("domain_reset", 32'(bus.domain_reset), 32'(e_dom));
    chk("all_released", 32'(bus.all_released), 32'(e_dom == 3'b000));
    chk("reset_cause", 32'(bus.reset_cause), 32'(m_cause));
    chk("warm_reset_count", 32'(bus.warm_reset_count), 32'(m_count));
    foreach (lits[i]) begin
      if (lits[i].ph == phase && lits[i].e == cyc) begin
        chk("lit_domain_reset", 32'(bus.domain_reset), 32'(lits[i].dom));
        chk("lit_all_released", 32'(bus.all_released), 32'(lits[i].ar));
        chk("lit_reset_cause", 32'(bus.reset_cause), 32'(lits[i].cause));
        chk("lit_warm_count", 32'(bus.warm_reset_count), 32'(lits[i].cnt));
      end
    end
  end

  // Wait for the falling edge that follows rising edge n.
  task automatic at_neg(input int n);
    int guard = 0;
    while (cyc != n && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 3000) begin
      $display("FAIL at_neg timeout waiting for edge %0d", n);
      $fatal(1);
    end
  endtask

  initial begin
    bus.ext_reset_n  = 1'b1;
    bus.sw_reset_req = 1'b0;
    reset = 1'b1;
    phase = 1;
    repeat (4) @(negedge clock);
    reset = 1'b0;

    // Software request while running.
    at_neg(39);  bus.sw_reset_req = 1'b1;
    at_neg(40);  bus.sw_reset_req = 1'b0;

    // Short glitch (5 samples), then a real 20-cycle press.
    at_neg(70);  bus.ext_reset_n = 1'b0;
    at_neg(75);  bus.ext_reset_n = 1'b1;
    at_neg(99);  bus.ext_reset_n = 1'b0;
    at_neg(119); bus.ext_reset_n = 1'b1;

    // Request in RUN, then another during RELEASE (domain 0 already out).
    at_neg(159); bus.sw_reset_req = 1'b1;
    at_neg(160); bus.sw_reset_req = 1'b0;
    at_neg(176); bus.sw_reset_req = 1'b1;
    at_neg(177); bus.sw_reset_req = 1'b0;

    // Button press debounced on edge 220 together with a software request.
    at_neg(209); bus.ext_reset_n = 1'b0;
    at_neg(219); bus.sw_reset_req = 1'b1;
    at_neg(220); bus.sw_reset_req = 1'b0;
    at_neg(229); bus.ext_reset_n = 1'b1;

    // 260 software requests push the count into saturation.
    for (int i = 0; i < 260; i++) begin
      at_neg(269 + 2 * i); bus.sw_reset_req = 1'b1;
      at_neg(270 + 2 * i); bus.sw_reset_req = 1'b0;
    end

    // System reset clears diagnostics and replays the full sequence.
    at_neg(830);
    reset = 1'b1;
    phase = 2;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    at_neg(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
